// File: rtl/conv_input_loader_pkg.sv
// Shared definitions for the conv input loader and the conv blocks that size their flat buses from it.
// Provides the loader state encoding and the tensor-size / index-width helpers.
package conv_input_loader_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    function automatic int tensor_total(input int b, input int c, input int h, input int w);
        return b * c * h * w;
    endfunction

    // A single-element tensor still needs a 1-bit index register
    function automatic int idx_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/conv_input_loader.sv
// Assembles a scalar valid/ready element stream into a flat tensor bus and hands it off with valid/ready.
//   state | meaning
//   FILL  | accepting elements into the buffer at idx, in_ready high
//   FULL  | tensor complete, tensor_flat frozen, waiting for tensor_ready
module conv_input_loader
    import conv_input_loader_pkg::*;
#(
    parameter int BATCH_SIZE      = 1,
    parameter int IN_CHANNELS     = 1,
    parameter int IN_HEIGHT       = 4,
    parameter int IN_WIDTH        = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int FRAME_CNT_WIDTH = 16,
    localparam int TOTAL = tensor_total(BATCH_SIZE, IN_CHANNELS, IN_HEIGHT, IN_WIDTH),
    localparam int IDX_W = idx_width(TOTAL)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [TOTAL*DATA_WIDTH-1:0] tensor_flat,
    output logic                        tensor_valid,
    input  logic                        tensor_ready,
    output logic                        err_early_last,
    output logic                        err_missing_last,
    output logic [FRAME_CNT_WIDTH-1:0]  frame_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   buf_mem [TOTAL];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= FILL;
            idx              <= '0;
            in_ready         <= 1'b0;
            tensor_valid     <= 1'b0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
            frame_count      <= '0;
            for (int i = 0; i < TOTAL; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (clear) begin
            state        <= FILL;
            idx          <= '0;
            in_ready     <= 1'b1;
            tensor_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    in_ready     <= 1'b1;
                    tensor_valid <= 1'b0;
                    if (in_valid && in_ready) begin
                        buf_mem[idx] <= in_data;
                        if (idx == LAST_IDX) begin
                            state        <= FULL;
                            idx          <= '0;
                            in_ready     <= 1'b0;
                            tensor_valid <= 1'b1;
                            if (!in_last) begin
                                err_missing_last <= 1'b1;
                            end
                        end else if (in_last) begin
                            // Short tensor: restart the fill, stale buffer words are simply overwritten
                            err_early_last <= 1'b1;
                            idx            <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (tensor_ready) begin
                        state        <= FILL;
                        frame_count  <= frame_count + 1'b1;
                        in_ready     <= 1'b1;
                        tensor_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    for (genvar g = 0; g < TOTAL; g++) begin : g_flat
        assign tensor_flat[g*DATA_WIDTH +: DATA_WIDTH] = buf_mem[g];
    end

endmodule

// File: tb/tb_conv_input_loader.sv
// Directed bench for conv_input_loader: fill, handoff, error flags, clear, reset and frame counter wrap.
module tb_conv_input_loader;

    localparam int DW    = 32;
    localparam int TOTAL = 16;
    localparam int FCW   = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  clear;
    logic [DW-1:0]         in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic [TOTAL*DW-1:0]   tensor_flat;
    logic                  tensor_valid;
    logic                  tensor_ready;
    logic                  err_early_last;
    logic                  err_missing_last;
    logic [FCW-1:0]        frame_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [TOTAL*DW-1:0] saved_flat;

    conv_input_loader #(
        .BATCH_SIZE(1), .IN_CHANNELS(1), .IN_HEIGHT(4), .IN_WIDTH(4),
        .DATA_WIDTH(DW), .FRAME_CNT_WIDTH(FCW)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .tensor_flat(tensor_flat), .tensor_valid(tensor_valid), .tensor_ready(tensor_ready),
        .err_early_last(err_early_last), .err_missing_last(err_missing_last),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive cnt elements starting at index first, data = base + index; in_last on index last_at (-1 = never)
    task automatic fill(input int base, input int first, input int cnt, input int last_at);
        for (int i = first; i < first + cnt; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(base + i);
            in_last  = (i == last_at);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic check_tensor(input string tag, input int base);
        for (int i = 0; i < TOTAL; i++) begin
            check(tag, 64'(tensor_flat[i*DW +: DW]), 64'(base + i));
        end
    endtask

    task automatic handoff();
        tensor_ready = 1'b1;
        tick();
        tensor_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; tensor_ready = 1'b0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_tvalid", 64'(tensor_valid), 64'd0);
        check("rst_frame", 64'(frame_count), 64'd0);
        check("rst_flat_zero", 64'(tensor_flat == '0), 64'd1);
        check("rst_errs", 64'({err_early_last, err_missing_last}), 64'd0);
        rst = 1'b1;
        tick();
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Back-to-back fill, valid exactly after the 16th accept
        fill(0, 0, 15, 15);
        check("tvalid_before_last", 64'(tensor_valid), 64'd0);
        fill(0, 15, 1, 15);
        check("tvalid_after_last", 64'(tensor_valid), 64'd1);
        check("in_ready_full", 64'(in_ready), 64'd0);
        check_tensor("data_t0", 0);
        check("errs_clean", 64'({err_early_last, err_missing_last}), 64'd0);

        // Stall in FULL with the producer still pushing
        saved_flat = tensor_flat;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 32'hBAD0_0000 + DW'(k);
            tick();
            check("stall_in_ready", 64'(in_ready), 64'd0);
            n_assert++;
            assert (tensor_flat === saved_flat) else begin
                n_fail++;
                $error("FAIL stall_flat_stable: observed %0h expected %0h", tensor_flat[63:0], saved_flat[63:0]);
            end
        end
        in_valid = 1'b0;
        handoff();
        check("frame_after_h1", 64'(frame_count), 64'd1);
        check("in_ready_after_h1", 64'(in_ready), 64'd1);
        check("tvalid_after_h1", 64'(tensor_valid), 64'd0);

        // in_last on idx 5
        fill(100, 0, 6, 5);
        check("early_flag", 64'(err_early_last), 64'd1);
        check("early_no_tvalid", 64'(tensor_valid), 64'd0);
        fill(200, 0, 15, 15);
        check("early_refill_not_done", 64'(tensor_valid), 64'd0);
        fill(200, 15, 1, 15);
        check("early_refill_done", 64'(tensor_valid), 64'd1);
        check_tensor("data_after_early", 200);
        check("missing_clean", 64'(err_missing_last), 64'd0);
        handoff();
        check("frame_after_h2", 64'(frame_count), 64'd2);

        // No in_last at all
        fill(300, 0, 16, -1);
        check("missing_flag", 64'(err_missing_last), 64'd1);
        check("missing_tvalid", 64'(tensor_valid), 64'd1);
        check_tensor("data_missing", 300);
        handoff();
        check("frame_after_h3", 64'(frame_count), 64'd3);

        // clear together with an element at idx 9
        fill(400, 0, 9, -1);
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; clear = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clear_tvalid", 64'(tensor_valid), 64'd0);
        check("clear_in_ready", 64'(in_ready), 64'd1);
        fill(500, 0, 15, 15);
        check("clear_idx_zero", 64'(tensor_valid), 64'd0);
        fill(500, 15, 1, 15);
        check("clear_refill_done", 64'(tensor_valid), 64'd1);
        check_tensor("data_after_clear", 500);

        // clear wins over tensor_ready in FULL
        clear = 1'b1; tensor_ready = 1'b1;
        tick();
        clear = 1'b0; tensor_ready = 1'b0;
        check("clear_full_frame", 64'(frame_count), 64'd3);
        check("clear_full_tvalid", 64'(tensor_valid), 64'd0);
        check("clear_full_in_ready", 64'(in_ready), 64'd1);
        check("clear_keeps_errs", 64'({err_early_last, err_missing_last}), 64'd3);

        // Asynchronous reset mid-fill at idx 7
        fill(600, 0, 7, -1);
        #2 rst = 1'b0;
        #1;
        check("arst_flat", 64'(tensor_flat == '0), 64'd1);
        check("arst_tvalid", 64'(tensor_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        check("arst_errs", 64'({err_early_last, err_missing_last}), 64'd0);
        check("arst_frame", 64'(frame_count), 64'd0);
        #1 rst = 1'b1;
        tick();
        check("arst_in_ready_back", 64'(in_ready), 64'd1);
        fill(700, 0, 16, 15);
        check("arst_fill_done", 64'(tensor_valid), 64'd1);
        check_tensor("data_after_arst", 700);
        handoff();
        check("arst_frame1", 64'(frame_count), 64'd1);

        // Frame counter wrap (4-bit instance: 16 handoffs return to 0)
        for (int k = 0; k < 14; k++) begin
            fill(800, 0, 16, 15);
            handoff();
        end
        check("frame_pre_wrap", 64'(frame_count), 64'd15);
        fill(900, 0, 16, 15);
        handoff();
        check("frame_wrap", 64'(frame_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
